// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word accesses into whole-word memory cycles,
// extracting and extending load lanes and doing read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        MemReadReq,
    input  logic        MemWriteReq,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Address,
    input  logic [31:0] StoreData,
    output logic [31:0] LoadData,
    output logic        Done,
    output logic        Fault,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWriteEn,
    output logic        MemReadEn,
    input  logic [31:0] MemReadData
);

    typedef enum logic [2:0] {IDLE, LOAD_RD, STORE_WR, RMW_RD, RMW_WR, FAULT_ST} state_t;

    state_t      state_q;
    logic [31:0] load_data_q, mem_addr_q, mem_wdata_q;
    logic        done_q, fault_q, mem_we_q, mem_re_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [15:0] sdata_q;

    logic        accept;
    logic        f3_legal_d, req_fault_d;
    logic [2:0]  size_d;
    logic [32:0] end_addr_d;

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [15:0] data,
                                                input logic [1:0]  off,
                                                input logic        half);
        logic [31:0] r;
        r = word;
        if (half) r[{off[1], 4'b0000} +: 16] = data;
        else      r[{off, 3'b000} +: 8]      = data[7:0];
        return r;
    endfunction

    assign ReqReady = Rst && (state_q == IDLE);
    assign accept   = ReqValid && ReqReady;

    always_comb begin
        size_d = 3'd4;
        case (Funct3[1:0])
            2'b00:   size_d = 3'd1;
            2'b01:   size_d = 3'd2;
            default: size_d = 3'd4;
        endcase
        f3_legal_d = 1'b0;
        case (Funct3)
            3'b000, 3'b001, 3'b010: f3_legal_d = 1'b1;
            3'b100, 3'b101:         f3_legal_d = MemReadReq;
            default:                f3_legal_d = 1'b0;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap back into range
        end_addr_d  = {1'b0, Address} + {30'b0, size_d};
        req_fault_d = (MemReadReq == MemWriteReq) || !f3_legal_d ||
                      (Funct3[1:0] == 2'b01 && Address[0]) ||
                      (Funct3[1:0] == 2'b10 && Address[1:0] != 2'b00) ||
                      (end_addr_d > 33'(MEM_BYTES));
    end

    // Request fields needed after accept; no reset needed, only read in busy states
    always_ff @(posedge Clk) begin
        if (accept) begin
            off_q   <= Address[1:0];
            f3_q    <= Funct3;
            sdata_q <= StoreData[15:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            load_data_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mem_addr_q <= {Address[31:2], 2'b00};
                        if (req_fault_d) begin
                            state_q <= FAULT_ST;
                        end else if (MemReadReq) begin
                            state_q  <= LOAD_RD;
                            mem_re_q <= 1'b1;
                        end else if (Funct3[1:0] == 2'b10) begin
                            state_q     <= STORE_WR;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= StoreData;
                        end else begin
                            state_q  <= RMW_RD;
                            mem_re_q <= 1'b1;
                        end
                    end
                end
                LOAD_RD: begin
                    load_data_q <= extract_load(MemReadData, f3_q, off_q);
                    mem_addr_q  <= '0;
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                end
                RMW_RD: begin
                    mem_wdata_q <= merge_store(MemReadData, sdata_q, off_q, f3_q[0]);
                    mem_we_q    <= 1'b1;
                    state_q     <= RMW_WR;
                end
                STORE_WR, RMW_WR: begin
                    mem_addr_q <= '0;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                FAULT_ST: begin
                    mem_addr_q <= '0;
                    done_q     <= 1'b1;
                    fault_q    <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign LoadData     = load_data_q;
    assign Done         = done_q;
    assign Fault        = fault_q;
    assign MemAddress   = mem_addr_q;
    assign MemWriteData = mem_wdata_q;
    assign MemWriteEn   = mem_we_q;
    assign MemReadEn    = mem_re_q;

endmodule
